// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register with load-use hazard detection for a 5-stage MIPS
//   pipeline. Decoded operands and control captured from ID are presented to EX
//   one cycle later. When the instruction in EX is a load whose destination is
//   read by the instruction in ID, the front end is stalled (stall_Id) and a
//   single bubble is injected. A saturating counter tracks those bubbles.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   hold                 downstream stall: freeze all ID/EX state and the counter
//   flush                branch/jump redirect: load a bubble
//   *_Id                 decoded instruction from ID (operands, regs, control)
//   *_Ex                 registered copy of the above presented to EX
//   stall_Id             combinational: hold PC and IF/ID this cycle
//   bubble_cnt           number of load-use bubbles inserted since reset
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              valid_Id,
  input  logic [REG_AW-1:0] Rs_Id,
  input  logic [REG_AW-1:0] Rt_Id,
  input  logic              uses_rt_Id,
  input  logic [REG_AW-1:0] Rd_Id,
  input  logic [DATA_W-1:0] busA_Id,
  input  logic [DATA_W-1:0] busB_Id,
  input  logic [DATA_W-1:0] Imm_Id,
  input  logic              RegWr_Id,
  input  logic              MemWr_Id,
  input  logic              MemRd_Id,
  input  logic              MemtoReg_Id,
  input  logic [2:0]        ALUSrcB_Id,
  input  logic [3:0]        ALUctr_Id,
  output logic              valid_Ex,
  output logic [REG_AW-1:0] Rs_Ex,
  output logic [REG_AW-1:0] Rt_Ex,
  output logic [REG_AW-1:0] Rd_Ex,
  output logic [DATA_W-1:0] busA_Ex,
  output logic [DATA_W-1:0] busB_Ex,
  output logic [DATA_W-1:0] Imm_Ex,
  output logic              RegWr_Ex,
  output logic              MemWr_Ex,
  output logic              MemRd_Ex,
  output logic              MemtoReg_Ex,
  output logic [2:0]        ALUSrcB_Ex,
  output logic [3:0]        ALUctr_Ex,
  output logic              stall_Id,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // One packed word per pipeline slot; an all-zero word is a bubble.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] bus_a;
    logic [DATA_W-1:0] bus_b;
    logic [DATA_W-1:0] imm;
    logic              reg_wr;
    logic              mem_wr;
    logic              mem_rd;
    logic              mem_to_reg;
    logic [2:0]        alu_src_b;
    logic [3:0]        alu_ctr;
  } slot_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  slot_t            ex_q, ex_d, id_slot;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;

  always_comb begin
    id_slot = '{
      valid:      valid_Id,
      rs:         Rs_Id,
      rt:         Rt_Id,
      rd:         Rd_Id,
      bus_a:      busA_Id,
      bus_b:      busB_Id,
      imm:        Imm_Id,
      reg_wr:     RegWr_Id,
      mem_wr:     MemWr_Id,
      mem_rd:     MemRd_Id,
      mem_to_reg: MemtoReg_Id,
      alu_src_b:  ALUSrcB_Id,
      alu_ctr:    ALUctr_Id
    };
  end

  // Load in EX writing a non-zero register that the ID instruction reads.
  // Decoded only from registered EX state so there is no path from the
  // downstream hold/flush into the compare.
  always_comb begin
    hazard = ex_q.valid && ex_q.mem_rd && ex_q.reg_wr && (ex_q.rd != '0) &&
             valid_Id &&
             ((ex_q.rd == Rs_Id) || (uses_rt_Id && (ex_q.rd == Rt_Id)));
  end

  // A flush discards the ID instruction anyway, so no stall is needed.
  // hold is deliberately not folded in here; the front end ORs it separately.
  assign stall_Id = hazard && !flush;

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (!hold) begin
      if (flush) begin
        ex_d = '0;
      end else if (hazard) begin
        ex_d = '0;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        ex_d = id_slot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid_Ex    = ex_q.valid;
  assign Rs_Ex       = ex_q.rs;
  assign Rt_Ex       = ex_q.rt;
  assign Rd_Ex       = ex_q.rd;
  assign busA_Ex     = ex_q.bus_a;
  assign busB_Ex     = ex_q.bus_b;
  assign Imm_Ex      = ex_q.imm;
  assign RegWr_Ex    = ex_q.reg_wr;
  assign MemWr_Ex    = ex_q.mem_wr;
  assign MemRd_Ex    = ex_q.mem_rd;
  assign MemtoReg_Ex = ex_q.mem_to_reg;
  assign ALUSrcB_Ex  = ex_q.alu_src_b;
  assign ALUctr_Ex   = ex_q.alu_ctr;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage (CNT_W=2 so saturation is reachable).
//   Directed load-use scenarios followed by randomized traffic, all checked
//   against a slot-level reference model of the pipeline register.
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n, hold, flush, valid_Id, uses_rt_Id;
  logic [REG_AW-1:0] Rs_Id, Rt_Id, Rd_Id;
  logic [DATA_W-1:0] busA_Id, busB_Id, Imm_Id;
  logic              RegWr_Id, MemWr_Id, MemRd_Id, MemtoReg_Id;
  logic [2:0]        ALUSrcB_Id;
  logic [3:0]        ALUctr_Id;
  logic              valid_Ex;
  logic [REG_AW-1:0] Rs_Ex, Rt_Ex, Rd_Ex;
  logic [DATA_W-1:0] busA_Ex, busB_Ex, Imm_Ex;
  logic              RegWr_Ex, MemWr_Ex, MemRd_Ex, MemtoReg_Ex;
  logic [2:0]        ALUSrcB_Ex;
  logic [3:0]        ALUctr_Ex;
  logic              stall_Id;
  logic [CNT_W-1:0]  bubble_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .valid_Id(valid_Id), .Rs_Id(Rs_Id), .Rt_Id(Rt_Id), .uses_rt_Id(uses_rt_Id),
    .Rd_Id(Rd_Id), .busA_Id(busA_Id), .busB_Id(busB_Id), .Imm_Id(Imm_Id),
    .RegWr_Id(RegWr_Id), .MemWr_Id(MemWr_Id), .MemRd_Id(MemRd_Id),
    .MemtoReg_Id(MemtoReg_Id), .ALUSrcB_Id(ALUSrcB_Id), .ALUctr_Id(ALUctr_Id),
    .valid_Ex(valid_Ex), .Rs_Ex(Rs_Ex), .Rt_Ex(Rt_Ex), .Rd_Ex(Rd_Ex),
    .busA_Ex(busA_Ex), .busB_Ex(busB_Ex), .Imm_Ex(Imm_Ex),
    .RegWr_Ex(RegWr_Ex), .MemWr_Ex(MemWr_Ex), .MemRd_Ex(MemRd_Ex),
    .MemtoReg_Ex(MemtoReg_Ex), .ALUSrcB_Ex(ALUSrcB_Ex), .ALUctr_Ex(ALUctr_Ex),
    .stall_Id(stall_Id), .bubble_cnt(bubble_cnt)
  );

  // Reference model: expected EX slot as a flat 123-bit word in port order,
  // plus the expected bubble count as a plain integer.
  localparam int SLOT_W = 1 + 3*REG_AW + 3*DATA_W + 4 + 3 + 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;
  logic [SLOT_W-1:0] m_slot = '0;
  int                m_cnt  = 0;

  function automatic logic [SLOT_W-1:0] id_word();
    return {valid_Id, Rs_Id, Rt_Id, Rd_Id, busA_Id, busB_Id, Imm_Id,
            RegWr_Id, MemWr_Id, MemRd_Id, MemtoReg_Id, ALUSrcB_Id, ALUctr_Id};
  endfunction

  function automatic logic [SLOT_W-1:0] ex_word();
    return {valid_Ex, Rs_Ex, Rt_Ex, Rd_Ex, busA_Ex, busB_Ex, Imm_Ex,
            RegWr_Ex, MemWr_Ex, MemRd_Ex, MemtoReg_Ex, ALUSrcB_Ex, ALUctr_Ex};
  endfunction

  // Does the instruction the model holds in EX make the ID instruction wait?
  function automatic bit model_hazard();
    bit              e_valid, e_regwr, e_memrd;
    int              e_rd;
    e_valid = m_slot[SLOT_W-1];
    e_rd    = int'(m_slot[SLOT_W-1-2*REG_AW-1 -: REG_AW]);
    e_regwr = m_slot[10];
    e_memrd = m_slot[8];
    return e_valid && e_memrd && e_regwr && e_rd != 0 && valid_Id &&
           (e_rd == int'(Rs_Id) || (uses_rt_Id && e_rd == int'(Rt_Id)));
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check stall mid-cycle, clock the model, check registered state.
  task automatic cycle(input string tag);
    bit haz;
    haz = model_hazard();
    #3;
    chk({tag, ".stall"}, 128'(stall_Id), 128'(haz && !flush));
    @(posedge clk);
    if (!rst_n) begin
      m_slot = '0; m_cnt = 0;
    end else if (!hold) begin
      if (flush) m_slot = '0;
      else if (haz) begin
        m_slot = '0;
        m_cnt  = (m_cnt < CNT_SAT) ? m_cnt + 1 : CNT_SAT;
      end else m_slot = id_word();
    end
    #1;
    chk({tag, ".ex"}, 128'(ex_word()), 128'(m_slot));
    chk({tag, ".cnt"}, 128'(bubble_cnt), 128'(m_cnt));
    $display("cycle %s: stall=%0b valid_Ex=%0b Rd_Ex=%0d cnt=%0d", tag, stall_Id,
             valid_Ex, Rd_Ex, bubble_cnt);
  endtask

  task automatic rand_id();
    valid_Id    = ($urandom % 4) != 0;
    Rs_Id       = 5'($urandom_range(0, 3));
    Rt_Id       = 5'($urandom_range(0, 3));
    Rd_Id       = 5'($urandom_range(0, 3));
    uses_rt_Id  = 1'($urandom);
    busA_Id     = $urandom;
    busB_Id     = $urandom;
    Imm_Id      = $urandom;
    RegWr_Id    = 1'($urandom);
    MemWr_Id    = 1'($urandom);
    MemRd_Id    = 1'($urandom);
    MemtoReg_Id = 1'($urandom);
    ALUSrcB_Id  = 3'($urandom);
    ALUctr_Id   = 4'($urandom);
  endtask

  task automatic put_load(input logic [REG_AW-1:0] rd);
    rand_id();
    valid_Id = 1'b1; MemRd_Id = 1'b1; RegWr_Id = 1'b1; Rd_Id = rd;
  endtask

  task automatic put_user(input logic [REG_AW-1:0] rs);
    rand_id();
    valid_Id = 1'b1; MemRd_Id = 1'b0; Rs_Id = rs; Rt_Id = 5'd31;
  endtask

  int exp_sat [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    rand_id();
    @(posedge clk); #1;
    cycle("reset");
    chk("reset.valid", 128'(valid_Ex), 128'(0));
    rst_n = 1'b1;

    // lw $5 then add using $5: one stall, one bubble, then add enters EX.
    put_load(5'd5); cycle("lw5");
    put_user(5'd5); cycle("use5_stall");
    chk("use5_stall.cnt1", 128'(bubble_cnt), 128'(1));
    cycle("use5_enter");
    chk("use5_enter.rs", 128'(Rs_Ex), 128'(5));

    // Rt matches but is not read: no stall.
    put_load(5'd7); cycle("lw7");
    put_user(5'd3); Rt_Id = 5'd7; uses_rt_Id = 1'b0; cycle("rt7_unused");

    // Load into $0, and a non-load writer: neither stalls.
    put_load(5'd0); cycle("lw0");
    put_user(5'd0); cycle("use0");
    put_user(5'd1); RegWr_Id = 1'b1; Rd_Id = 5'd5; cycle("alu5");
    put_user(5'd5); cycle("use_alu5");

    // Hazard together with flush: bubble, no stall, count unchanged.
    put_load(5'd9); cycle("lw9");
    put_user(5'd9); flush = 1'b1; cycle("flush_haz");
    flush = 1'b0;

    // Hazard under hold for 3 cycles, then release.
    put_load(5'd9); cycle("lw9b");
    put_user(5'd9); hold = 1'b1;
    for (int i = 0; i < 3; i++) cycle("hold_haz");
    hold = 1'b0;
    cycle("hold_release");
    cycle("hold_enter");

    // Saturation from a fresh reset: 1,2,3,3,3.
    rst_n = 1'b0; cycle("reset2"); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put_load(5'd4); cycle("sat_lw");
      put_user(5'd4); cycle("sat_stall");
      chk("sat.cnt", 128'(bubble_cnt), 128'(exp_sat[i]));
      cycle("sat_enter");
    end

    // Reset in the middle of a stall.
    put_load(5'd6); cycle("lw6");
    put_user(5'd6); rst_n = 1'b0; cycle("rst_mid_stall");
    rst_n = 1'b1; cycle("after_rst");
    chk("after_rst.stall", 128'(stall_Id), 128'(0));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_id();
      flush = ($urandom % 8) == 0;
      hold  = ($urandom % 6) == 0;
      rst_n = ($urandom % 60) != 0;
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
